// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Iterative restoring divider. Each clock produces one quotient bit.
//   Valid/ready handshakes sit on both the operand side and the result side.
//   A nonzero divisor gives a result WIDTH clocks after acceptance.
//   A zero divisor gives a result one clock after acceptance.
//
// Optional feature macro: SIGNED_DIV_EN
//   Undefined (default): unsigned operands.
//   Defined: two's-complement operands.
//     - The datapath divides the magnitudes.
//     - The quotient is negated when the operand signs differ.
//     - The remainder takes the dividend's sign.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands valid
//   in_ready     block can accept operands (state == IDLE)
//   dividend     dividend, WIDTH bits
//   divisor      divisor, WIDTH bits
//   out_valid    results valid
//   out_ready    consumer accepts results
//   quotient     quotient, WIDTH bits
//   remainder    remainder, WIDTH bits
//   div_by_zero  divisor was zero for this result
//   busy         state != IDLE

module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    // The partial remainder after restoration is always below the divisor,
    // so WIDTH bits hold it. The extra bit exists only in the trial difference.
    logic [WIDTH-1:0] r_reg;
    logic [CNT_W-1:0] cnt;
    // Set when the divisor was zero. The single CALC cycle then loads the
    // div-by-zero result, which gives out_valid one edge after acceptance.
    logic             dz_pend;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_trial;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;

`ifdef SIGNED_DIV_EN
    logic dvd_neg;
    logic quo_neg;
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        r_shift = {r_reg, q_reg[WIDTH-1]};
        r_trial = r_shift - {1'b0, d_reg};
        if (!r_trial[WIDTH]) begin
            r_next = r_trial[WIDTH-1:0];
            q_next = {q_reg[WIDTH-2:0], 1'b1};
        end else begin
            r_next = r_shift[WIDTH-1:0];
            q_next = {q_reg[WIDTH-2:0], 1'b0};
        end
`ifdef SIGNED_DIV_EN
        // The magnitude of -2^(WIDTH-1) still fits as an unsigned value.
        dvd_mag = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
        dvs_mag = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;
        fin_q   = quo_neg ? ('0 - q_next) : q_next;
        fin_r   = dvd_neg ? ('0 - r_next) : r_next;
`else
        dvd_mag = dividend;
        dvs_mag = divisor;
        fin_q   = q_next;
        fin_r   = r_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            dz_pend     <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            dvd_neg     <= 1'b0;
            quo_neg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_reg <= dvs_mag;
                        r_reg <= '0;
                        cnt   <= '0;
                        state <= CALC;
                        if (divisor == '0) begin
                            // Keep the raw dividend: it becomes the remainder.
                            dz_pend <= 1'b1;
                            q_reg   <= dividend;
                        end else begin
                            dz_pend <= 1'b0;
                            q_reg   <= dvd_mag;
                        end
`ifdef SIGNED_DIV_EN
                        dvd_neg <= dividend[WIDTH-1];
                        quo_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
`endif
                    end
                end
                CALC: begin
                    if (dz_pend) begin
                        quotient    <= '1;
                        remainder   <= q_reg;
                        div_by_zero <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        q_reg <= q_next;
                        r_reg <= r_next;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            quotient    <= fin_q;
                            remainder   <= fin_r;
                            div_by_zero <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
